// File: rtl/kalman_sequencer.sv
// Sample FIFO + update scheduler between the SPI deserializer, kalman_filter and parallel_2_serial.
// Optional WAIT_KF watchdog is compiled in with `define SEQ_WATCHDOG_EN.
module kalman_sequencer #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8,
    parameter int TIMEOUT    = 1024
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            z_valid,
    input  logic [DATA_W-1:0]               z_in,
    output logic                            kf_start,
    output logic [DATA_W-1:0]               kf_z,
    input  logic                            kf_done,
    input  logic [DATA_W-1:0]               kf_x,
    input  logic                            tx_ready,
    output logic                            tx_start,
    output logic [DATA_W-1:0]               tx_data,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            overrun,
    output logic [CNT_W-1:0]                drop_cnt,
    output logic                            timeout_err,
    input  logic                            clr_err
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, START, WAIT_KF, SEND} state_t;

    state_t              state, state_nxt;
    logic [DATA_W-1:0]   mem [FIFO_DEPTH];
    logic [LVL_W-1:0]    wr_ptr, rd_ptr;
    logic [DATA_W-1:0]   result;
    logic                empty, full, push, pop, drop, capture, send, wd_expire;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign fifo_level = wr_ptr - rd_ptr;
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (fifo_level == LVL_W'(FIFO_DEPTH));
    assign push       = z_valid && (!full || pop);
    assign drop       = z_valid && full && !pop;
    assign busy       = (state != IDLE) || !empty;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        kf_start  = 1'b0;
        capture   = 1'b0;
        send      = 1'b0;
        case (state)
            IDLE: if (!empty) begin
                pop       = 1'b1;
                state_nxt = START;
            end
            START: begin
                kf_start  = 1'b1;
                state_nxt = WAIT_KF;
            end
            WAIT_KF: if (kf_done) begin
                capture   = 1'b1;
                state_nxt = SEND;
            end else if (wd_expire) begin
                state_nxt = IDLE;
            end
            SEND: if (tx_ready) begin
                send      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PTR_W-1:0]] <= z_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            kf_z     <= '0;
            result   <= '0;
            tx_data  <= '0;
            tx_start <= 1'b0;
            overrun  <= 1'b0;
            drop_cnt <= '0;
        end else begin
            state    <= state_nxt;
            tx_start <= send;
            if (push) wr_ptr <= wr_ptr + LVL_W'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + LVL_W'(1);
                kf_z   <= mem[rd_ptr[PTR_W-1:0]];
            end
            if (capture) result <= kf_x;
            if (send) tx_data <= result;
            // A drop in the same cycle as clr_err leaves a count of exactly one.
            if (drop) begin
                overrun  <= 1'b1;
                drop_cnt <= clr_err ? CNT_W'(1) :
                            (&drop_cnt) ? drop_cnt : drop_cnt + CNT_W'(1);
            end else if (clr_err) begin
                overrun  <= 1'b0;
                drop_cnt <= '0;
            end
        end
    end

`ifdef SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT) + 1;
    logic [WD_W-1:0] wd_cnt;

    // Counter idles at zero outside WAIT_KF, so it is cleared on entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                wd_cnt <= '0;
        else if (state != WAIT_KF) wd_cnt <= '0;
        else                       wd_cnt <= wd_cnt + WD_W'(1);
    end

    assign wd_expire = (state == WAIT_KF) && (wd_cnt == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     timeout_err <= 1'b0;
        else if (wd_expire && !kf_done) timeout_err <= 1'b1;
        else if (clr_err)               timeout_err <= 1'b0;
    end
`else
    assign wd_expire   = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_kalman_sequencer.sv
// Self-checking bench for kalman_sequencer: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
`timescale 1ns/1ps
module tb_kalman_sequencer;
    localparam int DW = 16, DEPTH = 4, CW = 8, TMO = 16;

    logic clk = 1'b0, rst_n = 1'b0;
    logic z_valid = 1'b0, kf_done = 1'b0, tx_ready = 1'b0, clr_err = 1'b0;
    logic [DW-1:0] z_in = '0, kf_x = '0;
    logic kf_start, tx_start, busy, overrun, timeout_err;
    logic [DW-1:0] kf_z, tx_data;
    logic [$clog2(DEPTH):0] fifo_level;
    logic [CW-1:0] drop_cnt;

    kalman_sequencer #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .CNT_W(CW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .z_valid(z_valid), .z_in(z_in),
        .kf_start(kf_start), .kf_z(kf_z), .kf_done(kf_done), .kf_x(kf_x),
        .tx_ready(tx_ready), .tx_start(tx_start), .tx_data(tx_data),
        .busy(busy), .fifo_level(fifo_level), .overrun(overrun), .drop_cnt(drop_cnt),
        .timeout_err(timeout_err), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: a sample queue plus where the one in-flight sample is in its lifecycle
    // (0 none, 1 being requested, 2 in the filter, 3 result waiting for the serializer).
    logic [DW-1:0] mq[$];
    int            m_phase, m_drop, m_wd;
    logic [DW-1:0] m_z, m_res, m_txd;
    bit            m_txs, m_ovr, m_terr;

    task automatic m_reset();
        mq.delete();
        m_phase = 0; m_drop = 0; m_wd = 0;
        m_z = '0; m_res = '0; m_txd = '0;
        m_txs = 0; m_ovr = 0; m_terr = 0;
    endtask

    initial m_reset();

    always @(negedge clk) begin
        bit nxt_txs, tmo, dropped;
        if (!rst_n) begin
            m_reset();
        end else begin
            chk("kf_start",    kf_start,    m_phase == 1);
            chk("kf_z",        kf_z,        m_z);
            chk("tx_start",    tx_start,    m_txs);
            chk("tx_data",     tx_data,     m_txd);
            chk("busy",        busy,        (m_phase != 0) || (mq.size() != 0));
            chk("fifo_level",  fifo_level,  mq.size());
            chk("overrun",     overrun,     m_ovr);
            chk("drop_cnt",    drop_cnt,    m_drop);
            chk("timeout_err", timeout_err, m_terr);
            nxt_txs = 0; tmo = 0; dropped = 0;
            case (m_phase)
                0: if (mq.size() > 0) begin m_z = mq.pop_front(); m_phase = 1; end
                1: begin m_phase = 2; m_wd = 0; end
                2: if (kf_done) begin m_res = kf_x; m_phase = 3; end
`ifdef SEQ_WATCHDOG_EN
                   else if (m_wd == TMO - 1) begin tmo = 1; m_phase = 0; end
                   else m_wd++;
`endif
                3: if (tx_ready) begin m_txd = m_res; nxt_txs = 1; m_phase = 0; end
                default: m_phase = 0;
            endcase
            m_txs = nxt_txs;
            if (z_valid) begin
                if (mq.size() < DEPTH) mq.push_back(z_in);
                else dropped = 1;
            end
            if (dropped) begin
                m_ovr  = 1;
                m_drop = clr_err ? 1 : (m_drop == 255 ? 255 : m_drop + 1);
            end else if (clr_err) begin
                m_ovr = 0; m_drop = 0;
            end
            if (tmo) m_terr = 1;
            else if (clr_err) m_terr = 0;
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic wait_start();
        int n = 0;
        while (kf_start !== 1'b1 && n < 200) begin cyc(); n++; end
        chk("kf_start_seen", kf_start, 1);
    endtask

    // In WAIT_KF: one kf_done pulse; returns in the SEND cycle.
    task automatic serve_cur(input logic [DW-1:0] x);
        kf_done = 1'b1; kf_x = x;
        cyc();
        kf_done = 1'b0;
    endtask

    task automatic serve(input logic [DW-1:0] zexp, input logic [DW-1:0] x);
        wait_start();
        chk("serve_kf_z", kf_z, zexp);
        cyc();
        serve_cur(x);
    endtask

    initial begin #1ms; $display("FAIL global_timeout: simulation did not finish"); $fatal(1); end

    logic [DW-1:0] a [6];
    int cnt;

    initial begin
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();

        // single sample, exact latency
        z_valid = 1; z_in = 16'h1234;
        cyc(); z_valid = 0;
        chk("lat_c1_kf_start", kf_start, 0);
        cyc();
        chk("lat_c2_kf_start", kf_start, 1);
        chk("lat_c2_kf_z", kf_z, 16'h1234);
        cyc();
        kf_done = 1; kf_x = 16'h1200; tx_ready = 1;
        cyc(); kf_done = 0;
        chk("lat_n1_tx_start", tx_start, 0);
        cyc();
        chk("lat_n2_tx_start", tx_start, 1);
        chk("lat_n2_tx_data", tx_data, 16'h1200);
        chk("lat_n2_busy", busy, 0);
        cyc();

        // burst of four while the filter is busy
        for (int i = 0; i < 4; i++) a[i] = 16'hA1 + DW'(i);
        for (int i = 0; i < 4; i++) begin z_valid = 1; z_in = a[i]; cyc(); end
        z_valid = 0;
        chk("burst_level", fifo_level, 3);
        chk("burst_first_z", kf_z, a[0]);
        serve_cur(16'h0B01);
        for (int i = 1; i < 4; i++) serve(a[i], 16'h0B01 + DW'(i));
        chk("burst_no_overrun", overrun, 0);
        cyc(); cyc();

        // overrun: six samples into a stalled pipeline
        for (int i = 0; i < 6; i++) a[i] = 16'hC0 + DW'(i);
        for (int i = 0; i < 6; i++) begin z_valid = 1; z_in = a[i]; cyc(); end
        z_valid = 0;
        chk("ovr_flag", overrun, 1);
        chk("ovr_cnt", drop_cnt, 1);
        chk("ovr_level", fifo_level, 4);
        clr_err = 1; cyc(); clr_err = 0;
        chk("ovr_clr_flag", overrun, 0);
        chk("ovr_clr_cnt", drop_cnt, 0);
        serve_cur(16'h0D00);
        for (int i = 1; i < 5; i++) serve(a[i], 16'h0D00 + DW'(i));
        cyc(); cyc();
        chk("ovr_drained_busy", busy, 0);

        // drop counter saturation
        for (int i = 0; i < 300; i++) begin z_valid = 1; z_in = DW'($urandom); cyc(); end
        z_valid = 0;
        chk("sat_cnt", drop_cnt, 8'hFF);

        // asynchronous reset mid-operation
        rst_n = 0; #1;
        chk("rst_kf_start", kf_start, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_kf_z", kf_z, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_timeout", timeout_err, 0);
        cyc(); rst_n = 1; cyc();
        kf_done = 1; kf_x = 16'hDEAD; cyc(); kf_done = 0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin cyc(); cnt += int'(tx_start); end
        chk("stray_done_tx", cnt, 0);

        // backpressure on the serializer
        tx_ready = 0;
        z_valid = 1; z_in = 16'hB001; cyc(); z_valid = 0;
        serve(16'hB001, 16'h5A5A);
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            z_valid = (i == 3 || i == 4);
            z_in = (i == 3) ? 16'hB002 : 16'hB003;
            cyc();
            cnt += int'(tx_start);
        end
        z_valid = 0;
        chk("bp_held", cnt, 0);
        chk("bp_level", fifo_level, 2);
        tx_ready = 1; cyc();
        chk("bp_tx_start", tx_start, 1);
        chk("bp_tx_data", tx_data, 16'h5A5A);
        cyc();
        chk("bp_single", tx_start, 0);
        chk("bp_next_start", kf_start, 1);
        chk("bp_next_z", kf_z, 16'hB002);
        cyc();
        serve_cur(16'h0E02);
        serve(16'hB003, 16'h0E03);
        cyc(); cyc();

`ifdef SEQ_WATCHDOG_EN
        // watchdog: filter never answers
        z_valid = 1; z_in = 16'h7001; cyc(); z_in = 16'h7002; cyc(); z_valid = 0;
        wait_start();
        repeat (16) cyc();
        chk("wd_not_yet", timeout_err, 0);
        cyc();
        chk("wd_err", timeout_err, 1);
        chk("wd_no_tx", tx_start, 0);
        cyc();
        chk("wd_next_start", kf_start, 1);
        chk("wd_next_z", kf_z, 16'h7002);
        cyc();
        serve_cur(16'h0F00);
        cyc(); cyc();
        clr_err = 1; cyc(); clr_err = 0;
        chk("wd_clr", timeout_err, 0);
`endif

        // randomized traffic against the model
        for (int seg = 0; seg < 8; seg++) begin
            int rate;
            rate = (seg % 2) ? 70 : 15;
            for (int i = 0; i < 500; i++) begin
                z_valid  = ($urandom_range(0, 99) < rate);
                z_in     = DW'($urandom);
                kf_done  = ($urandom_range(0, 4) == 0);
                kf_x     = DW'($urandom);
                tx_ready = ($urandom_range(0, 2) != 0);
                clr_err  = ($urandom_range(0, 63) == 0);
                cyc();
            end
        end
        z_valid = 0; kf_done = 0; clr_err = 0;
        repeat (3) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
